flag_alu_pipe: RTL and testbench

//  Parametrised, registered successor of the combinational adder-with-flags.

---
 rtl/flag_alu_pkg.sv | 35 +++
 rtl/flag_alu_pipe_if.sv | 41 ++++
 rtl/flag_alu_flags.sv | 35 +++
 rtl/flag_alu_pipe.sv | 127 ++++++++++++
 tb/tb_flag_alu_pipe.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/flag_alu_pkg.sv
// Shared types and helpers for the flag ALU pipeline.
//   op_e    : 3-bit opcode. All 8 encodings are defined.
//   flags_t : the flag set that comes with every result beat.
//   is_sub  : the op is a subtract type (SUB/SBB).
//   is_arith: the op goes through the adder (ADD/SUB/ADC/SBB).
package flag_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_ADC  = 3'd2,
    OP_SBB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef struct packed {
    logic sign;
    logic carry;
    logic zero;
    logic parity;
    logic ovf;
  } flags_t;

  function automatic logic is_sub(op_e op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

  function automatic logic is_arith(op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBB);
  endfunction

endpackage

// File: rtl/flag_alu_pipe_if.sv
// Stream interface of flag_alu_pipe.
//   Operand side : in_valid, in_ready, in_op, in_x, in_y
//   Result side  : out_valid, out_ready, out_z, out_sign, out_carry,
//                  out_zero, out_parity, out_ovf
//   Flag control : cf_q (architectural carry), clr_flags
// The master modport is the operand sequencer / writeback side.
// The slave modport is the ALU.
interface flag_alu_pipe_if #(
  parameter int WIDTH = 16
);
  import flag_alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_e              in_op;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_z;
  logic             out_sign;
  logic             out_carry;
  logic             out_zero;
  logic             out_parity;
  logic             out_ovf;
  logic             cf_q;
  logic             clr_flags;

  modport master (
    output in_valid, in_op, in_x, in_y, out_ready, clr_flags,
    input  in_ready, out_valid, out_z, out_sign, out_carry, out_zero,
           out_parity, out_ovf, cf_q
  );

  modport slave (
    input  in_valid, in_op, in_x, in_y, out_ready, clr_flags,
    output in_ready, out_valid, out_z, out_sign, out_carry, out_zero,
           out_parity, out_ovf, cf_q
  );

endinterface

// File: rtl/flag_alu_flags.sv
// Combinational flag generation for one ALU result.
//   z        in  WIDTH  result word
//   carry    in  1      adder bit WIDTH (carry or borrow)
//   x_msb    in  1      sign bit of operand X
//   y_msb    in  1      sign bit of operand Y
//   is_sub   in  1      subtract-type op
//   is_arith in  1      op went through the adder
//   flags    out        sign/carry/zero/parity/ovf
module flag_alu_flags
  import flag_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] z,
  input  logic             carry,
  input  logic             x_msb,
  input  logic             y_msb,
  input  logic             is_sub,
  input  logic             is_arith,
  output flags_t           flags
);

  // Add overflows when the operands agree in sign and the result disagrees.
  // Subtract overflows when the operands differ in sign and the result
  // disagrees with X.
  logic sign_rule;
  assign sign_rule = ((x_msb ^ y_msb) == is_sub);

  assign flags.sign   = z[WIDTH-1];
  assign flags.carry  = is_arith & carry;
  assign flags.zero   = (z == '0);
  assign flags.parity = ~^z;
  assign flags.ovf    = is_arith & sign_rule & (z[WIDTH-1] != x_msb);

endmodule

// File: rtl/flag_alu_pipe.sv
// Registered ALU with flags over a valid/ready stream.
// Each accepted beat runs one of 8 ops. The result and its flags come out
// one cycle later. cf_q holds the carry of the last accepted op, so that
// ADC/SBB can chain multi-word arithmetic.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : flag_alu_pipe_if.slave (operands, results, flags, clr_flags)
// Build option:
//   FLAG_ALU_STICKY_OVF_EN defined -> out_ovf is sticky. It is set by any
//   accepted overflow and is held until clr_flags or rst.
//   Without it, out_ovf is the overflow of the beat currently in out_z.
module flag_alu_pipe
  import flag_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  flag_alu_pipe_if.slave    bus
);

  logic             out_valid_q;
  logic [WIDTH-1:0] z_q;
  flags_t           flags_q;
  logic             cf_q;

  logic             accept;
  logic             cf_eff;
  logic [WIDTH:0]   ax;
  logic [WIDTH:0]   ay;
  logic [WIDTH:0]   sum;
  flags_t           flags_next;

  // The slot frees up when it is empty or when it is popped this cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // A clear in the same cycle as an accept takes effect before the op reads
  // the carry.
  assign cf_eff = cf_q && !bus.clr_flags;

  // NOTE: every combinational output gets a default before the case. A path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    ax  = {1'b0, bus.in_x};
    ay  = {1'b0, bus.in_y};
    sum = '0;
    case (bus.in_op)
      OP_ADD:  sum = ax + ay;
      OP_SUB:  sum = ax - ay;
      OP_ADC:  sum = ax + ay + {{WIDTH{1'b0}}, cf_eff};
      OP_SBB:  sum = ax - ay - {{WIDTH{1'b0}}, cf_eff};
      OP_AND:  sum = ax & ay;
      OP_OR:   sum = ax | ay;
      OP_XOR:  sum = ax ^ ay;
      OP_PASS: sum = ax;
      default: sum = '0;
    endcase
  end

  flag_alu_flags #(.WIDTH(WIDTH)) u_flags (
    .z        (sum[WIDTH-1:0]),
    .carry    (sum[WIDTH]),
    .x_msb    (bus.in_x[WIDTH-1]),
    .y_msb    (bus.in_y[WIDTH-1]),
    .is_sub   (is_sub(bus.in_op)),
    .is_arith (is_arith(bus.in_op)),
    .flags    (flags_next)
  );

  // NOTE: state registers use non-blocking assignments only. Every register
  // in this block then sees the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
      flags_q     <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      z_q         <= sum[WIDTH-1:0];
      flags_q     <= flags_next;
    end else if (bus.out_ready) begin
      // Popped with nothing behind it. The data stays, but it is no longer valid.
      out_valid_q <= 1'b0;
    end
  end

  // Logic ops write carry=0, so any accept overwrites cf_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cf_q <= 1'b0;
    end else if (accept) begin
      cf_q <= flags_next.carry;
    end else if (bus.clr_flags) begin
      cf_q <= 1'b0;
    end
  end

`ifdef FLAG_ALU_STICKY_OVF_EN
  logic ovf_sticky_q;

  // A new overflow wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky_q <= 1'b0;
    end else if (accept && flags_next.ovf) begin
      ovf_sticky_q <= 1'b1;
    end else if (bus.clr_flags) begin
      ovf_sticky_q <= 1'b0;
    end
  end

  assign bus.out_ovf = ovf_sticky_q;
`else
  assign bus.out_ovf = flags_q.ovf;
`endif

  assign bus.out_valid  = out_valid_q;
  assign bus.out_z      = z_q;
  assign bus.out_sign   = flags_q.sign;
  assign bus.out_carry  = flags_q.carry;
  assign bus.out_zero   = flags_q.zero;
  assign bus.out_parity = flags_q.parity;
  assign bus.cf_q       = cf_q;

endmodule

// File: tb/tb_flag_alu_pipe.sv
// Self-checking bench for flag_alu_pipe (WIDTH=16).
// It runs directed scenarios first, then randomized traffic. Each cycle is
// compared with a cycle-level model that computes results with signed and
// unsigned integer arithmetic.
module tb_flag_alu_pipe;
  import flag_alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  flag_alu_pipe_if #(.WIDTH(W)) bus ();

  flag_alu_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: the beat sitting in the output slot, plus the flag registers.
  bit           m_valid;
  logic [W-1:0] m_z;
  bit           m_carry;
  bit           m_ovf;
  bit           m_cf;
  bit           m_sov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: the value as a wide integer. Carry/borrow is "result left
  // the unsigned range". Overflow is "result left the signed range".
  function automatic void ref_op(input op_e op, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input bit cin, output logic [W-1:0] z,
                                 output bit carry, output bit ovf);
    longint ux, uy, sx, sy, r, sr;
    bit arith;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = 0; sr = 0; arith = 1'b1; z = '0;
    case (op)
      OP_ADD: begin r = ux + uy;                    sr = sx + sy;                    end
      OP_SUB: begin r = ux - uy;                    sr = sx - sy;                    end
      OP_ADC: begin r = ux + uy + longint'(cin);    sr = sx + sy + longint'(cin);    end
      OP_SBB: begin r = ux - uy - longint'(cin);    sr = sx - sy - longint'(cin);    end
      OP_AND: begin arith = 1'b0; z = x & y; end
      OP_OR:  begin arith = 1'b0; z = x | y; end
      OP_XOR: begin arith = 1'b0; z = x ^ y; end
      default: begin arith = 1'b0; z = x; end
    endcase
    carry = 1'b0;
    ovf   = 1'b0;
    if (arith) begin
      z     = r[W-1:0];
      carry = (r < 0) || (r >= (longint'(1) << W));
      ovf   = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, bus.out_valid, m_valid);
    check({tag, ".cf_q"},  bus.cf_q,      m_cf);
    if (m_valid) begin
      check({tag, ".z"},      bus.out_z,      m_z);
      check({tag, ".sign"},   bus.out_sign,   m_z[W-1]);
      check({tag, ".carry"},  bus.out_carry,  m_carry);
      check({tag, ".zero"},   bus.out_zero,   m_z == '0);
      check({tag, ".parity"}, bus.out_parity, ($countones(m_z) % 2) == 0);
`ifndef FLAG_ALU_STICKY_OVF_EN
      check({tag, ".ovf"},    bus.out_ovf,    m_ovf);
`endif
    end
`ifdef FLAG_ALU_STICKY_OVF_EN
    check({tag, ".ovf_sticky"}, bus.out_ovf, m_sov);
`endif
  endtask

  // One clock cycle. Inputs are driven just after the falling edge, the model
  // steps at the rising edge, and outputs are checked at the next falling edge.
  task automatic cycle(input string tag, input bit v, input op_e op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input bit rdy, input bit clr);
    bit acc, cin, c, o;
    logic [W-1:0] z;
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_x      = x;
    bus.in_y      = y;
    bus.out_ready = rdy;
    bus.clr_flags = clr;
    #1;
    check({tag, ".in_ready"}, bus.in_ready, !m_valid || rdy);
    @(posedge clk);
    acc = v && (!m_valid || rdy);
    cin = clr ? 1'b0 : m_cf;
    if (acc) begin
      ref_op(op, x, y, cin, z, c, o);
      m_valid = 1'b1;
      m_z     = z;
      m_carry = c;
      m_ovf   = o;
      m_cf    = c;
      if (o) m_sov = 1'b1;
      else if (clr) m_sov = 1'b0;
    end else begin
      if (rdy) m_valid = 1'b0;
      if (clr) begin
        m_cf  = 1'b0;
        m_sov = 1'b0;
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_z = '0; m_carry = 1'b0; m_ovf = 1'b0; m_cf = 1'b0; m_sov = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners [5];
    corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'h7FFF;
    corners[3] = 16'h8000; corners[4] = 16'hFFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = OP_ADD; bus.in_x = '0; bus.in_y = '0;
    bus.out_ready = 1'b0; bus.clr_flags = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    // Reset state
    check("rst.valid",  bus.out_valid, 1'b0);
    check("rst.z",      bus.out_z,     '0);
    check("rst.flags",  {bus.out_sign, bus.out_carry, bus.out_zero, bus.out_parity, bus.out_ovf}, 5'b0);
    check("rst.cf_q",   bus.cf_q,      1'b0);
    rst = 1'b0;

    // ADD wrap, then a chained ADC
    cycle("add_wrap", 1, OP_ADD, 16'hFFFF, 16'h0001, 1, 0);
    check("add_wrap.z_const", bus.out_z, 16'h0000);
    check("add_wrap.flags_const",
          {bus.out_sign, bus.out_carry, bus.out_zero, bus.out_parity, bus.out_ovf}, 5'b01110);
    check("add_wrap.cf_const", bus.cf_q, 1'b1);
    cycle("adc_chain", 1, OP_ADC, 16'h0000, 16'h0000, 1, 0);
    check("adc_chain.z_const", bus.out_z, 16'h0001);
    check("adc_chain.carry_const", bus.out_carry, 1'b0);

    // Signed overflow on ADD
    cycle("add_ovf", 1, OP_ADD, 16'h7FFF, 16'h0001, 1, 0);
    check("add_ovf.const",
          {bus.out_z, bus.out_sign, bus.out_carry, bus.out_zero, bus.out_parity, bus.out_ovf},
          {16'h8000, 5'b10001});

    // SUB borrow. The clear also resets sticky ovf in that build.
    cycle("sub_borrow", 1, OP_SUB, 16'h0000, 16'h0001, 1, 1);
    check("sub_borrow.const",
          {bus.out_z, bus.out_sign, bus.out_carry, bus.out_parity, bus.out_ovf},
          {16'hFFFF, 4'b1110});
    cycle("sub_ovf", 1, OP_SUB, 16'h8000, 16'h0001, 1, 0);
    check("sub_ovf.const", {bus.out_z, bus.out_ovf}, {16'h7FFF, 1'b1});

    // Two clean ops, then a standalone clear
    cycle("clean1", 1, OP_AND, 16'h00F0, 16'h0FF0, 1, 0);
    cycle("clean2", 1, OP_OR,  16'h0001, 16'h0002, 1, 0);
`ifdef FLAG_ALU_STICKY_OVF_EN
    check("sticky.held", bus.out_ovf, 1'b1);
`endif
    cycle("clr_only", 0, OP_ADD, 16'h0000, 16'h0000, 1, 1);
`ifdef FLAG_ALU_STICKY_OVF_EN
    check("sticky.cleared", bus.out_ovf, 1'b0);
`endif

    // Clear with a simultaneous accept: ADC sees cf=0
    cycle("set_cf", 1, OP_ADD, 16'hFFFF, 16'h0001, 1, 0);
    cycle("clr_adc", 1, OP_ADC, 16'h0000, 16'h0000, 1, 1);
    check("clr_adc.z_const", bus.out_z, 16'h0000);

    // Backpressure: the first beat is held for 3 cycles and the second stalls
    cycle("bp_first", 1, OP_XOR, 16'h1234, 16'h00FF, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("bp_stall", 1, OP_ADD, 16'h1111, 16'h2222, 0, 0);
      check("bp_stall.z_const", bus.out_z, 16'h12CB);
    end
    cycle("bp_release", 1, OP_ADD, 16'h1111, 16'h2222, 1, 0);
    check("bp_release.z_const", bus.out_z, 16'h3333);
    cycle("bp_drain", 0, OP_ADD, 16'h0000, 16'h0000, 1, 0);

    // Async reset while a beat is waiting
    cycle("pre_rst", 1, OP_ADD, 16'hFFFF, 16'h0001, 0, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst.valid", bus.out_valid, 1'b0);
    check("mid_rst.cf_q",  bus.cf_q,      1'b0);
    check("mid_rst.z",     bus.out_z,     '0);
    check("mid_rst.in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst", 1, OP_SBB, 16'h0005, 16'h0003, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle("rand", $urandom_range(0, 3) != 0, op_e'($urandom_range(0, 7)), pick(), pick(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
